// File: rtl/sha_ctrl_pkg.sv
// Shared types for the Keccak core arbiter: FSM state encoding and SHA mode codes.
// The mode codes are what requesters place on TUSER.
package sha_ctrl_pkg;

  localparam int unsigned TUSER_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  typedef enum logic [TUSER_W-1:0] {
    SHA3_224 = 4'd0,
    SHA3_256 = 4'd1,
    SHA3_384 = 4'd2,
    SHA3_512 = 4'd3
  } sha_mode_t;

endpackage

// File: rtl/sha_core_arbiter_if.sv
// Requester-side AXI-Stream bundle, core-side stream and status for the Keccak core arbiter.
// master is the arbiter view; slave is the requesters/core view.
interface sha_core_arbiter_if
  import sha_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 2
);

  logic [N_REQ-1:0]            s_tvalid;
  logic [N_REQ-1:0]            s_tready;
  logic [N_REQ*DATA_WIDTH-1:0] s_tdata;
  logic [N_REQ-1:0]            s_tlast;
  logic [N_REQ*TUSER_W-1:0]    s_tuser;

  logic                        m_tvalid;
  logic                        m_tready;
  logic [DATA_WIDTH-1:0]       m_tdata;
  logic                        m_tlast;
  logic [TUSER_W-1:0]          m_tuser;
  logic [ID_WIDTH-1:0]         m_tid;

  logic                        core_done;
  logic                        busy;
  logic                        err_mode;
  logic                        err_done;

  modport master (
    input  s_tvalid, s_tdata, s_tlast, s_tuser, m_tready, core_done,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, m_tid,
           busy, err_mode, err_done
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, s_tuser, m_tready, core_done,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, m_tid,
           busy, err_mode, err_done
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1, wrapping at N_REQ-1.
// Modulo arithmetic keeps the index in range for non-power-of-2 requester counts.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  always_comb begin
    int unsigned cand;
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(last_grant) + k) % N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!gnt_valid && (i == cand) && req[i]) begin
          gnt_valid = 1'b1;
          gnt_oh[i] = 1'b1;
          gnt_idx   = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/sha_core_arbiter.sv
// Shares one Keccak absorb/permute datapath between N_REQ AXI-Stream requesters.
// Whole messages are granted round-robin; the grant is held until the core reports digest done.
module sha_core_arbiter
  import sha_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 2
) (
  input logic              ACLK,
  input logic              ARESETn,
  sha_core_arbiter_if.master bus
);

  localparam int unsigned TW = TUSER_W;

  state_t                  state, state_d;
  logic [N_REQ-1:0]        gnt_oh;
  logic [ID_WIDTH-1:0]     last_grant;
  logic [ID_WIDTH-1:0]     tid;
  logic [TW-1:0]           mode;
  logic                    busy_q;
  logic                    err_mode_q;
  logic                    err_done_q;

  logic [N_REQ-1:0]        arb_oh;
  logic [ID_WIDTH-1:0]     arb_idx;
  logic                    arb_valid;

  logic                    sel_valid;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_last;
  logic [TW-1:0]           sel_user;
  logic [TW-1:0]           grant_user;

  logic                    take_grant;
  logic                    mode_err;
  logic                    m_tvalid_c;
  logic [DATA_WIDTH-1:0]   m_tdata_c;
  logic                    m_tlast_c;
  logic [N_REQ-1:0]        s_tready_c;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (ID_WIDTH)
  ) u_rr (
    .req        (bus.s_tvalid),
    .last_grant (last_grant),
    .gnt_oh     (arb_oh),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_valid)
  );

  // One-hot select of the granted lane, and of the lane about to be granted for mode capture
  always_comb begin
    sel_valid  = 1'b0;
    sel_data   = '0;
    sel_last   = 1'b0;
    sel_user   = '0;
    grant_user = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_valid = bus.s_tvalid[i];
        sel_data  = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last  = bus.s_tlast[i];
        sel_user  = bus.s_tuser[i*TW +: TW];
      end
      if (arb_oh[i]) begin
        grant_user = bus.s_tuser[i*TW +: TW];
      end
    end
  end

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and stream pass-through
  always_comb begin
    state_d    = state;
    take_grant = 1'b0;
    mode_err   = 1'b0;
    m_tvalid_c = 1'b0;
    m_tdata_c  = '0;
    m_tlast_c  = 1'b0;
    s_tready_c = '0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          take_grant = 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        m_tvalid_c = sel_valid;
        m_tdata_c  = sel_data;
        m_tlast_c  = sel_last;
        s_tready_c = gnt_oh & {N_REQ{bus.m_tready}};
        if (sel_valid && bus.m_tready) begin
          mode_err = (sel_user != mode);
          if (sel_last) begin
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.core_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, tag, mode and status registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      gnt_oh     <= '0;
      last_grant <= ID_WIDTH'(N_REQ - 1);
      tid        <= '0;
      mode       <= '0;
      busy_q     <= 1'b0;
      err_mode_q <= 1'b0;
      err_done_q <= 1'b0;
    end else begin
      busy_q     <= (state_d != IDLE);
      err_mode_q <= mode_err;
      err_done_q <= bus.core_done && (state != WAIT_DONE);
      if (take_grant) begin
        gnt_oh     <= arb_oh;
        last_grant <= arb_idx;
        tid        <= arb_idx;
        mode       <= grant_user;
      end
    end
  end

  assign bus.m_tvalid = m_tvalid_c;
  assign bus.m_tdata  = m_tdata_c;
  assign bus.m_tlast  = m_tlast_c;
  assign bus.s_tready = s_tready_c;
  assign bus.m_tuser  = mode;
  assign bus.m_tid    = tid;
  assign bus.busy     = busy_q;
  assign bus.err_mode = err_mode_q;
  assign bus.err_done = err_done_q;

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Directed bench for sha_core_arbiter: grant order, stream pass-through, error pulses and reset.
// Expected values are hand-derived from the arbitration rules.
module tb_sha_core_arbiter;
  import sha_ctrl_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 2;

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;

  always #5 ACLK = ~ACLK;

  sha_core_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  sha_core_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus.master)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int em_cnt = 0;
  int ed_cnt = 0;
  logic [DW-1:0] beats [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Passive monitor, sampled mid-cycle
  always @(negedge ACLK) begin
    if (bus.m_tvalid && bus.m_tready) beats.push_back(bus.m_tdata);
    if (bus.err_mode) em_cnt++;
    if (bus.err_done) ed_cnt++;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input int r, input logic v, input logic [DW-1:0] d,
                       input logic l, input logic [3:0] u);
    bus.s_tvalid[r]          = v;
    bus.s_tdata[r*DW +: DW]  = d;
    bus.s_tlast[r]           = l;
    bus.s_tuser[r*4 +: 4]    = u;
  endtask

  task automatic clear_inputs();
    bus.s_tvalid  = '0;
    bus.s_tdata   = '0;
    bus.s_tlast   = '0;
    bus.s_tuser   = '0;
    bus.core_done = 1'b0;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    clear_inputs();
    repeat (2) tick();
    ARESETn = 1'b1;
    tick();
  endtask

  // Push nb beats on an already granted requester; beat 'bad' carries bad_mode on TUSER
  task automatic stream(input int r, input int nb, input logic [DW-1:0] base,
                        input logic [3:0] mode, input int bad, input logic [3:0] bad_mode);
    for (int i = 0; i < nb; i++) begin
      int waitc;
      waitc = 0;
      drive(r, 1'b1, base + DW'(i), (i == nb - 1), (i == bad) ? bad_mode : mode);
      #1;
      while (!(bus.s_tready[r] && bus.m_tready) && waitc < 50) begin
        tick();
        #1;
        waitc++;
      end
      check("stream_timeout", 32'(waitc < 50), 32'd1);
      check("stream_data", 32'(bus.m_tdata), 32'(base + DW'(i)));
      check("stream_last", 32'(bus.m_tlast), 32'(i == nb - 1));
      check("stream_user", 32'(bus.m_tuser), 32'(mode));
      tick();
    end
    drive(r, 1'b0, '0, 1'b0, 4'd0);
  endtask

  task automatic finish_msg(input string tag);
    check({tag, "_wait_valid"}, 32'(bus.m_tvalid), 32'd0);
    check({tag, "_wait_rdy"}, 32'(bus.s_tready), 32'd0);
    check({tag, "_wait_busy"}, 32'(bus.busy), 32'd1);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ord [5];
    int bi;
    int k;
    int em0;
    int ed0;
    logic v;
    logic acc;

    ord = '{0, 1, 2, 3, 0};
    clear_inputs();
    bus.m_tready = 1'b0;
    #13;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("rst_tready", 32'(bus.s_tready), 32'd0);
    check("rst_tid", 32'(bus.m_tid), 32'd0);
    check("rst_tuser", 32'(bus.m_tuser), 32'd0);
    check("rst_errs", 32'({bus.err_mode, bus.err_done}), 32'd0);
    ARESETn = 1'b1;
    tick();

    // 1: single requester 2, 3-beat message
    bus.m_tready = 1'b1;
    drive(2, 1'b1, 16'hA000, 1'b0, 4'd1);
    #1;
    check("t1_idle_rdy", 32'(bus.s_tready), 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    check("t1_tid", 32'(bus.m_tid), 32'd2);
    check("t1_mode", 32'(bus.m_tuser), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    beats.delete();
    stream(2, 3, 16'hA000, 4'd1, -1, 4'd0);
    repeat (3) tick();
    finish_msg("t1");
    check("t1_nbeats", 32'(beats.size()), 32'd3);
    check("t1_beat2", 32'(beats[2]), 32'hA002);
    check("t1_tid_idle", 32'(bus.m_tid), 32'd2);

    // 2: all four valid -> grant order 0,1,2,3,0
    do_reset();
    bus.m_tready = 1'b1;
    for (int m = 0; m < 5; m++) begin
      for (int r = 0; r < 4; r++) drive(r, 1'b1, 16'(r * 256 + m * 16), 1'b0, 4'(r));
      tick();
      check("t2_tid", 32'(bus.m_tid), 32'(ord[m]));
      check("t2_mode", 32'(bus.m_tuser), 32'(ord[m]));
      stream(ord[m], 2, 16'(ord[m] * 256 + m * 16), 4'(ord[m]), -1, 4'd0);
      finish_msg("t2");
    end
    clear_inputs();

    // 3: requester 1 with m_tready toggling and tvalid gaps
    tick();
    beats.delete();
    drive(1, 1'b1, 16'h3000, 1'b0, 4'd2);
    tick();
    check("t3_tid", 32'(bus.m_tid), 32'd1);
    bi = 0;
    k  = 0;
    while (bi < 4 && k < 60) begin
      v = ((k % 3) != 2);
      bus.m_tready = ((k % 2) == 0);
      if (v) drive(1, 1'b1, 16'h3000 + 16'(bi), (bi == 3), 4'd2);
      else   bus.s_tvalid[1] = 1'b0;
      #1;
      check("t3_rdy", 32'(bus.s_tready), bus.m_tready ? 32'h2 : 32'h0);
      acc = v && bus.m_tready;
      tick();
      if (acc) bi++;
      k++;
    end
    drive(1, 1'b0, '0, 1'b0, 4'd0);
    bus.m_tready = 1'b1;
    check("t3_done", 32'(bi), 32'd4);
    check("t3_nbeats", 32'(beats.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beats.size()) check("t3_order", 32'(beats[i]), 32'h3000 + 32'(i));
    end
    check("t3_mode", 32'(bus.m_tuser), 32'd2);
    finish_msg("t3");

    // 4: TUSER changes on beat 1 -> forwarded, mode held, one err_mode pulse
    drive(2, 1'b1, 16'h4000, 1'b0, 4'd1);
    tick();
    check("t4_tid", 32'(bus.m_tid), 32'd2);
    em0 = em_cnt;
    stream(2, 3, 16'h4000, 4'd1, 1, 4'd3);
    tick();
    check("t4_err_mode", 32'(em_cnt - em0), 32'd1);
    check("t4_mode_held", 32'(bus.m_tuser), 32'd1);
    finish_msg("t4");

    // 5: core_done in STREAM and in IDLE -> err_done, state unaffected
    bus.m_tready = 1'b0;
    drive(3, 1'b1, 16'h5000, 1'b0, 4'd0);
    tick();
    check("t5_tid", 32'(bus.m_tid), 32'd3);
    ed0 = ed_cnt;
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    check("t5_busy", 32'(bus.busy), 32'd1);
    check("t5_tvalid", 32'(bus.m_tvalid), 32'd1);
    check("t5_tdata", 32'(bus.m_tdata), 32'h5000);
    tick();
    check("t5_err_done", 32'(ed_cnt - ed0), 32'd1);
    bus.m_tready = 1'b1;
    stream(3, 2, 16'h5000, 4'd0, -1, 4'd0);
    finish_msg("t5");
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    tick();
    check("t5_err_done_idle", 32'(ed_cnt - ed0), 32'd2);
    check("t5_idle_busy", 32'(bus.busy), 32'd0);

    // 6: reset during beat 1 of 4, then req 0 beats req 3 in a tie
    drive(1, 1'b1, 16'h6000, 1'b0, 4'd2);
    tick();
    check("t6_tid", 32'(bus.m_tid), 32'd1);
    tick();
    drive(1, 1'b1, 16'h6001, 1'b0, 4'd2);
    #2;
    ARESETn = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(bus.m_tvalid), 32'd0);
    check("t6_rst_tready", 32'(bus.s_tready), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_tid", 32'(bus.m_tid), 32'd0);
    check("t6_rst_tuser", 32'(bus.m_tuser), 32'd0);
    check("t6_rst_tdata", 32'(bus.m_tdata), 32'd0);
    drive(1, 1'b0, '0, 1'b0, 4'd0);
    drive(0, 1'b1, 16'h6100, 1'b1, 4'd3);
    drive(3, 1'b1, 16'h6300, 1'b1, 4'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    tick();
    check("t6_tie_tid", 32'(bus.m_tid), 32'd0);
    check("t6_tie_mode", 32'(bus.m_tuser), 32'd3);
    stream(0, 1, 16'h6100, 4'd3, -1, 4'd0);
    finish_msg("t6");
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
